// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared spi_master register map, CTRL layout, flash opcode and sequencer states
package spi_pkg;

    // spi_master register addresses
    localparam logic [3:0] REG_STATUS   = 4'd0;
    localparam logic [3:0] REG_DATA_OUT = 4'd1;
    localparam logic [3:0] REG_DATA_IN  = 4'd2;
    localparam logic [3:0] REG_CTRL     = 4'd3;

    // CTRL layout: [7:3] clock divider, [2] slave select, [1:0] {CPOL,CPHA}
    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_SS_BIT   = 2;
    localparam int CTRL_DIV_LSB  = 3;

    // STATUS layout
    localparam int STATUS_BUSY_BIT = 0;

    // SPI-flash READ opcode
    localparam logic [7:0] OP_READ = 8'h03;

    // Header is opcode plus three address bytes; index 4 marks the data phase
    localparam logic [2:0] HDR_LAST = 3'd3;
    localparam logic [2:0] HDR_DATA = 3'd4;

    typedef enum logic [3:0] {
        ST_INIT = 4'd0,
        ST_IDLE = 4'd1,
        ST_SEL  = 4'd2,
        ST_TX   = 4'd3,
        ST_POLL = 4'd4,
        ST_CHK  = 4'd5,
        ST_RD   = 4'd6,
        ST_CAPT = 4'd7,
        ST_HOLD = 4'd8,
        ST_END  = 4'd9
    } seq_state_e;

    function automatic logic [7:0] ctrl_byte(input logic [4:0] div,
                                             input logic       ss,
                                             input logic [1:0] mode);
        logic [7:0] b;
        b = 8'h00;
        b[CTRL_DIV_LSB +: 5]  = div;
        b[CTRL_SS_BIT]        = ss;
        b[CTRL_MODE_LSB +: 2] = mode;
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_seq.sv
// rtl/spi_flash_seq.sv - SPI-flash READ sequencer driving spi_master registers; optional SPI_FLASH_SEQ_TIMEOUT_EN
module spi_flash_seq
    import spi_pkg::*;
#(
    parameter logic [4:0] CLK_DIV  = 5'd3,
    parameter logic [1:0] SPI_MODE = 2'b00,
    parameter int         TIMEOUT  = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_faddr,
    input  logic [15:0] i_len,
    input  logic        i_abort,
    output logic        o_busy,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_done,
    output logic        o_err,
    output logic        o_spi_en,
    output logic        o_spi_wr,
    output logic [3:0]  o_spi_addr,
    output logic [7:0]  o_spi_data,
    input  logic [7:0]  i_spi_data
);

    localparam logic [7:0] CTRL_ON  = ctrl_byte(CLK_DIV, 1'b1, SPI_MODE);
    localparam logic [7:0] CTRL_OFF = ctrl_byte(CLK_DIV, 1'b0, SPI_MODE);

    seq_state_e  state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  hdr_q, hdr_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [7:0]  tx_byte;
    logic        abortable;

`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Abort only acts once the sequencer owns an open transaction
    assign abortable = (state_q != ST_INIT) && (state_q != ST_IDLE) && (state_q != ST_END);

    // Byte shifted out in TX: opcode, address MSB first, then dummy bytes for data
    always_comb begin
        tx_byte = 8'h00;
        case (hdr_q)
            3'd0:    tx_byte = OP_READ;
            3'd1:    tx_byte = addr_q[23:16];
            3'd2:    tx_byte = addr_q[15:8];
            3'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_INIT;
            addr_q  <= 24'h0;
            len_q   <= 16'h0;
            hdr_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = i_faddr;
                    len_d   = i_len;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                hdr_d   = 3'd0;
                state_d = ST_TX;
            end
            ST_TX: begin
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_POLL;
            end
            ST_POLL: begin
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
                cnt_d   = cnt_q + 1'b1;
`endif
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (i_spi_data[STATUS_BUSY_BIT]) begin
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
                    if (cnt_q >= CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = ST_END;
                    end else begin
                        state_d = ST_POLL;
                    end
`else
                    state_d = ST_POLL;
`endif
                end else if (hdr_q != HDR_DATA) begin
                    hdr_d = hdr_q + 3'd1;
                    if ((hdr_q == HDR_LAST) && (len_q == 16'd0)) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_TX;
                    end
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RD: state_d = ST_CAPT;
            ST_CAPT: begin
                data_d  = i_spi_data;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    if (len_q != 16'd0) begin
                        len_d = len_q - 16'd1;
                    end
                    state_d = (len_q <= 16'd1) ? ST_END : ST_TX;
                end
            end
            ST_END: begin
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
                err_d   = 1'b0;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        // Abort overrides everything else; an aborted transaction never reports a timeout
        if (i_abort && abortable) begin
            valid_d = 1'b0;
            state_d = ST_END;
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end
    end

    // Register-bus access decoded from the current state, at most one strobe per cycle
    always_comb begin
        o_spi_en   = 1'b0;
        o_spi_wr   = 1'b0;
        o_spi_addr = REG_STATUS;
        o_spi_data = 8'h00;
        case (state_q)
            ST_INIT, ST_END: begin
                o_spi_en   = 1'b1;
                o_spi_wr   = 1'b1;
                o_spi_addr = REG_CTRL;
                o_spi_data = CTRL_OFF;
            end
            ST_SEL: begin
                o_spi_en   = 1'b1;
                o_spi_wr   = 1'b1;
                o_spi_addr = REG_CTRL;
                o_spi_data = CTRL_ON;
            end
            ST_TX: begin
                o_spi_en   = 1'b1;
                o_spi_wr   = 1'b1;
                o_spi_addr = REG_DATA_OUT;
                o_spi_data = tx_byte;
            end
            ST_POLL: begin
                o_spi_en   = 1'b1;
                o_spi_addr = REG_STATUS;
            end
            ST_RD: begin
                o_spi_en   = 1'b1;
                o_spi_addr = REG_DATA_IN;
            end
            default: begin
                o_spi_en   = 1'b0;
            end
        endcase
    end

    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_END);
    assign o_valid = valid_q;
    assign o_data  = data_q;
`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
    assign o_err   = (state_q == ST_END) && err_q;
`else
    assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_seq.sv
// tb/tb_spi_flash_seq.sv - scoreboard bench for spi_flash_seq with a reactive spi_master model
module tb_spi_flash_seq;
    import spi_pkg::*;

    localparam logic [1:0] EV_WR   = 2'd0;
    localparam logic [1:0] EV_BYTE = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, abort, ready;
    logic [23:0] faddr;
    logic [15:0] len;
    logic        o_busy, o_valid, o_done, o_err;
    logic [7:0]  o_data;
    logic        o_spi_en, o_spi_wr;
    logic [3:0]  o_spi_addr;
    logic [7:0]  o_spi_data;
    logic [7:0]  spi_rdata;

    evt_t        exp_q[$];
    logic [7:0]  rx_q[$];
    int          busy_polls;
    bit          busy_forever;
    int          busy_cnt;
    int          status_reads = 0;
    int          checks = 0;
    int          errors = 0;

    spi_flash_seq #(
        .CLK_DIV (5'd3),
        .SPI_MODE(2'b00),
        .TIMEOUT (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_faddr   (faddr),
        .i_len     (len),
        .i_abort   (abort),
        .o_busy    (o_busy),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (ready),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_spi_en  (o_spi_en),
        .o_spi_wr  (o_spi_wr),
        .o_spi_addr(o_spi_addr),
        .o_spi_data(o_spi_data),
        .i_spi_data(spi_rdata)
    );

    always #5 clk = ~clk;

    // spi_master model: each DATA_OUT write stays busy for busy_polls STATUS reads
    always @(posedge clk) begin
        if (rst) begin
            spi_rdata <= 8'h00;
            busy_cnt  <= 0;
        end else if (o_spi_en) begin
            if (o_spi_wr && o_spi_addr == REG_DATA_OUT) begin
                busy_cnt <= busy_polls;
            end else if (!o_spi_wr && o_spi_addr == REG_STATUS) begin
                spi_rdata <= {7'b0, (busy_forever || busy_cnt != 0)};
                if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            end else if (!o_spi_wr && o_spi_addr == REG_DATA_IN) begin
                if (rx_q.size() != 0) spi_rdata <= rx_q.pop_front();
                else spi_rdata <= 8'hEE;
            end
        end
    end

    task automatic push(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
        evt_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL evt_unexpected got kind=%0d addr=%0d data=0x%02h expected none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL evt got kind=%0d addr=%0d data=0x%02h expected kind=%0d addr=%0d data=0x%02h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: compares every bus write, accepted byte and done pulse against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (o_spi_en && !o_spi_wr && o_spi_addr == REG_STATUS) status_reads++;
            if (o_spi_en && o_spi_wr) check_evt(EV_WR, o_spi_addr, o_spi_data);
            if (o_valid && ready) check_evt(EV_BYTE, 4'd0, o_data);
            if (o_done) check_evt(EV_DONE, 4'd0, {7'b0, o_err});
            if (o_err && !o_done) begin
                errors++;
                $display("FAIL err_without_done got o_err=1 o_done=0 expected o_err=0");
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_txn(input logic [23:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        faddr = a;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name, output bit saw_valid);
        int n;
        n = 0;
        saw_valid = 1'b0;
        do begin
            @(negedge clk);
            if (o_valid) saw_valid = 1'b1;
            n++;
        end while (o_busy && n < budget);
        chk(name, {31'b0, o_busy}, 32'd0);
    endtask

    task automatic push_hdr(input logic [23:0] a);
        push(EV_WR, REG_CTRL, 8'h1C);
        push(EV_WR, REG_DATA_OUT, 8'h03);
        push(EV_WR, REG_DATA_OUT, a[23:16]);
        push(EV_WR, REG_DATA_OUT, a[15:8]);
        push(EV_WR, REG_DATA_OUT, a[7:0]);
    endtask

    task automatic push_end(input logic err);
        push(EV_WR, REG_CTRL, 8'h18);
        push(EV_DONE, 4'd0, {7'b0, err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired expected simulation end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         sv;
        int         n;
        int         dcnt;
        int         base;
        logic [7:0] held;

        start = 0; abort = 0; ready = 1; faddr = 0; len = 0;
        busy_polls = 0; busy_forever = 0;

        // Reset state, then CTRL_OFF write in the first cycle after release
        push(EV_WR, REG_CTRL, 8'h18);
        @(negedge clk);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_err", {31'b0, o_err}, 32'd0);
        chk("rst_data", {24'b0, o_data}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("init_wr", {o_spi_en, o_spi_wr, o_spi_addr, o_spi_data}, {1'b1, 1'b1, 4'd3, 8'h18});
        chk("init_busy", {31'b0, o_busy}, 32'd1);
        @(negedge clk);
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
        chk("init_sb", exp_q.size(), 32'd0);

        // Two-byte read with one busy poll per byte; stray start mid-transaction is ignored
        busy_polls = 1;
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h5A);
        push_hdr(24'h123456);
        push(EV_WR, REG_DATA_OUT, 8'h00);
        push(EV_BYTE, 4'd0, 8'hA5);
        push(EV_WR, REG_DATA_OUT, 8'h00);
        push(EV_BYTE, 4'd0, 8'h5A);
        push_end(1'b0);
        start_txn(24'h123456, 16'd2);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; faddr = 24'hFFFFFF; len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(300, "t2_idle", sv);
        chk("t2_sb", exp_q.size(), 32'd0);

        // Zero length: header only, no data byte
        busy_polls = 0;
        push_hdr(24'hABCDEF);
        push_end(1'b0);
        start_txn(24'hABCDEF, 16'd0);
        wait_idle(200, "t3_idle", sv);
        chk("t3_no_valid", {31'b0, sv}, 32'd0);
        chk("t3_sb", exp_q.size(), 32'd0);

        // Consumer stalls for 10 cycles: byte held stable, bus quiet
        ready = 0;
        rx_q.push_back(8'h77);
        push_hdr(24'h000010);
        push(EV_WR, REG_DATA_OUT, 8'h00);
        push(EV_BYTE, 4'd0, 8'h77);
        push_end(1'b0);
        start_txn(24'h000010, 16'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 200);
        chk("t4_valid_seen", {31'b0, o_valid}, 32'd1);
        held = o_data;
        chk("t4_data", {24'b0, held}, 32'h77);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'b0, o_valid}, 32'd1);
            chk("t4_hold_data", {24'b0, o_data}, {24'b0, held});
            chk("t4_hold_bus", {31'b0, o_spi_en}, 32'd0);
        end
        @(posedge clk); #1;
        ready = 1;
        wait_idle(200, "t4_idle", sv);
        chk("t4_sb", exp_q.size(), 32'd0);

        // Abort while polling the third header byte, then restart one cycle after END
        busy_polls = 5;
        push(EV_WR, REG_CTRL, 8'h1C);
        push(EV_WR, REG_DATA_OUT, 8'h03);
        push(EV_WR, REG_DATA_OUT, 8'hA1);
        push(EV_WR, REG_DATA_OUT, 8'hB2);
        push_end(1'b0);
        push_hdr(24'h001122);
        push_end(1'b0);
        start_txn(24'hA1B2C3, 16'd3);
        dcnt = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (o_spi_en && o_spi_wr && o_spi_addr == REG_DATA_OUT) dcnt++;
            n++;
        end while (dcnt < 3 && n < 200);
        chk("t5_third_hdr", dcnt, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("t5_abort_wr", {o_spi_en, o_spi_wr, o_spi_addr, o_spi_data}, {1'b1, 1'b1, 4'd3, 8'h18});
        chk("t5_abort_done", {31'b0, o_done}, 32'd1);
        @(posedge clk); #1;
        start = 1; faddr = 24'h001122; len = 16'd0;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("t5_restart_sel", {o_spi_en, o_spi_wr, o_spi_addr, o_spi_data}, {1'b1, 1'b1, 4'd3, 8'h1C});
        wait_idle(300, "t5_idle", sv);
        chk("t5_sb", exp_q.size(), 32'd0);
        busy_polls = 0;

`ifdef SPI_FLASH_SEQ_TIMEOUT_EN
        // Master never leaves busy: eight polls then END with o_err
        busy_forever = 1;
        base = status_reads;
        push(EV_WR, REG_CTRL, 8'h1C);
        push(EV_WR, REG_DATA_OUT, 8'h03);
        push_end(1'b1);
        start_txn(24'h000000, 16'd1);
        wait_idle(200, "t6_idle", sv);
        chk("t6_status_reads", status_reads - base, 32'd8);
        chk("t6_sb", exp_q.size(), 32'd0);
        busy_forever = 0;
`else
        base = status_reads;
`endif

        repeat (3) @(negedge clk);
        chk("final_sb", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
